lcd_hd44780_ctrl: RTL and testbench

//  - Hardware HD44780 character-LCD driver that sits between the core's LCD I/O write port and the board LCD pins.
//  - Replaces software bit-banging of LCD_EN/RS/RW/DATA.
//  - After reset: waits out power-up, then issues the fixed init sequence.
//  - Then accepts one byte per valid/ready handshake.
//  - Per byte: generates a registered setup -> EN pulse -> hold -> execution-wait cycle.

---
 rtl/lcd_hd44780_ctrl_pkg.sv | 31 +++
 rtl/lcd_hd44780_ctrl_if.sv | 19 +
 rtl/lcd_cycle_timer.sv | 22 ++
 rtl/lcd_hd44780_ctrl.sv | 174 +++++++++++++++++
 tb/tb_lcd_hd44780_ctrl.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_hd44780_ctrl_pkg.sv
// rtl/lcd_hd44780_ctrl_pkg.sv - shared types, init ROM and helpers for the HD44780 controller
package lcd_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    INIT_LD,
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    WAIT
  } lcd_state_e;

  localparam int LCD_INIT_LEN = 6;

  // Function set 8-bit/2-line x3, display on, clear, entry mode increment.
  localparam logic [7:0] LCD_INIT_SEQ [LCD_INIT_LEN] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

  // Clear and home are the only instructions that need the long execution wait.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == LCD_CMD_CLEAR) || (data == LCD_CMD_HOME));
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_hd44780_ctrl_if.sv
// rtl/lcd_hd44780_ctrl_if.sv - write-request handshake and status between requester and LCD controller
interface lcd_hd44780_ctrl_if;
  logic       req_valid_i;
  logic       req_ready_o;
  logic       req_rs_i;
  logic [7:0] req_data_i;
  logic       init_done_o;
  logic       busy_o;

  modport master (
    output req_valid_i, req_rs_i, req_data_i,
    input  req_ready_o, init_done_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_rs_i, req_data_i,
    output req_ready_o, init_done_o, busy_o
  );
endinterface

// File: rtl/lcd_cycle_timer.sv
// rtl/lcd_cycle_timer.sv - loadable down-counter that saturates at zero
module lcd_cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] value,
  output logic             done
);

  always_ff @(posedge clk_i) begin
    if (load) begin
      value <= load_val;
    end else if (value != '0) begin
      value <= value - 1'b1;
    end
  end

  assign done = (value == '0);

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// rtl/lcd_hd44780_ctrl.sv - HD44780 driver: power-up wait, init ROM replay, then one byte per handshake
module lcd_hd44780_ctrl
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYC    = 750_000,
  parameter int SETUP_CYC      = 4,
  parameter int EN_PULSE_CYC   = 25,
  parameter int HOLD_CYC       = 4,
  parameter int CMD_WAIT_CYC   = 2_000,
  parameter int CLEAR_WAIT_CYC = 80_000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  lcd_hd44780_ctrl_if.slave    req,
  output logic [7:0]           lcd_data_o,
  output logic                 lcd_rs_o,
  output logic                 lcd_rw_o,
  output logic                 lcd_en_o,
  output logic                 lcd_on_o
);

  localparam int MAX_CYC = max_int(max_int(max_int(POWERUP_CYC, SETUP_CYC + 1), max_int(EN_PULSE_CYC, HOLD_CYC)),
                                   max_int(CMD_WAIT_CYC, CLEAR_WAIT_CYC));
  localparam int TW = $clog2(MAX_CYC) + 1;

  lcd_state_e state_q, state_d;
  logic [2:0] k_q, k_d;
  logic       cur_rs_q, cur_rs_d;
  logic [7:0] cur_data_q, cur_data_d;
  logic [7:0] data_q, data_d;
  logic       rs_q, rs_d;
  logic       en_q, en_d;
  logic       ready_q, ready_d;
  logic       done_q, done_d;
  logic       busy_q;
  logic       on_q;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic [TW-1:0] tmr_value;
  logic          tmr_done;

  lcd_cycle_timer #(.WIDTH(TW)) u_timer (
    .clk_i   (clk_i),
    .load    (tmr_load),
    .load_val(tmr_val),
    .value   (tmr_value),
    .done    (tmr_done)
  );

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    cur_rs_d   = cur_rs_q;
    cur_data_d = cur_data_q;
    data_d     = data_q;
    rs_d       = rs_q;
    en_d       = 1'b0;
    ready_d    = 1'b0;
    done_d     = done_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;

    case (state_q)
      PWRUP: begin
        if (tmr_done) state_d = INIT_LD;
      end
      INIT_LD: begin
        cur_rs_d   = 1'b0;
        cur_data_d = LCD_INIT_SEQ[k_q];
        rs_d       = 1'b0;
        data_d     = LCD_INIT_SEQ[k_q];
        tmr_load   = 1'b1;
        tmr_val    = TW'(SETUP_CYC - 1);
        state_d    = SETUP;
      end
      IDLE: begin
        ready_d = done_q;
        if (req.req_valid_i && ready_q) begin
          cur_rs_d   = req.req_rs_i;
          cur_data_d = req.req_data_i;
          ready_d    = 1'b0;
          // One extra SETUP cycle: the pins pick up the captured byte one edge after accept.
          tmr_load   = 1'b1;
          tmr_val    = TW'(SETUP_CYC);
          state_d    = SETUP;
        end
      end
      SETUP: begin
        rs_d   = cur_rs_q;
        data_d = cur_data_q;
        if (tmr_done) begin
          en_d     = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = TW'(EN_PULSE_CYC - 1);
          state_d  = PULSE;
        end
      end
      PULSE: begin
        en_d = 1'b1;
        if (tmr_done) begin
          en_d     = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = TW'(HOLD_CYC - 1);
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = is_slow_cmd(cur_rs_q, cur_data_q) ? TW'(CLEAR_WAIT_CYC - 1) : TW'(CMD_WAIT_CYC - 1);
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (tmr_done) begin
          if (!done_q && (k_q != 3'(LCD_INIT_LEN - 1))) begin
            k_d     = k_q + 3'd1;
            state_d = INIT_LD;
          end else begin
            done_d  = 1'b1;
            ready_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = PWRUP;
    endcase

    // Reset preloads the power-up interval so PWRUP starts counting on the first released edge.
    if (rst_i) begin
      tmr_load = 1'b1;
      tmr_val  = TW'(POWERUP_CYC - 1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= PWRUP;
      k_q        <= '0;
      cur_rs_q   <= 1'b0;
      cur_data_q <= '0;
      data_q     <= '0;
      rs_q       <= 1'b0;
      en_q       <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b1;
      on_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      cur_rs_q   <= cur_rs_d;
      cur_data_q <= cur_data_d;
      data_q     <= data_d;
      rs_q       <= rs_d;
      en_q       <= en_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      busy_q     <= ~ready_d;
      on_q       <= 1'b1;
    end
  end

  assign lcd_data_o      = data_q;
  assign lcd_rs_o        = rs_q;
  assign lcd_rw_o        = 1'b0;
  assign lcd_en_o        = en_q;
  assign lcd_on_o        = on_q;
  assign req.req_ready_o = ready_q;
  assign req.init_done_o = done_q;
  assign req.busy_o      = busy_q;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// tb/tb_lcd_hd44780_ctrl.sv - directed table-driven bench for lcd_hd44780_ctrl
module tb_lcd_hd44780_ctrl;

  localparam int P_PWR = 20;
  localparam int P_S   = 2;
  localparam int P_EN  = 4;
  localparam int P_H   = 2;
  localparam int P_CMD = 10;
  localparam int P_CLR = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en, lcd_on;

  int n_tests = 0;
  int n_fail  = 0;

  lcd_hd44780_ctrl_if bus ();

  lcd_hd44780_ctrl #(
    .POWERUP_CYC   (P_PWR),
    .SETUP_CYC     (P_S),
    .EN_PULSE_CYC  (P_EN),
    .HOLD_CYC      (P_H),
    .CMD_WAIT_CYC  (P_CMD),
    .CLEAR_WAIT_CYC(P_CLR)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req       (bus),
    .lcd_data_o(lcd_data),
    .lcd_rs_o  (lcd_rs),
    .lcd_rw_o  (lcd_rw),
    .lcd_en_o  (lcd_en),
    .lcd_on_o  (lcd_on)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         wait_cyc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int t = 0;
    @(negedge clk);
    while (!bus.req_ready_o && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!bus.req_ready_o) check({name, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, 32'(lcd_data), 32'h00);
    check({tag, "_rs"}, 32'(lcd_rs), 32'd0);
    check({tag, "_rw"}, 32'(lcd_rw), 32'd0);
    check({tag, "_en"}, 32'(lcd_en), 32'd0);
    check({tag, "_on"}, 32'(lcd_on), 32'd0);
    check({tag, "_ready"}, 32'(bus.req_ready_o), 32'd0);
    check({tag, "_init_done"}, 32'(bus.init_done_o), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy_o), 32'd1);
  endtask

  // Called at a negedge with rst high; releases reset and follows the whole init replay.
  task automatic run_init(input bit hold_req);
    logic [7:0] exp_seq [6];
    int         rise_t [6];
    int         fall_t [6];
    logic [7:0] rise_d [6];
    int         nr = 0;
    int         done_t = -1;
    bit         pe = 1'b0;
    bit         rs_seen = 1'b0;
    bit         early = 1'b0;
    int         gap;
    exp_seq = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    for (int i = 0; i < 6; i++) begin
      rise_t[i] = -1;
      fall_t[i] = -1;
      rise_d[i] = 8'h00;
    end
    bus.req_valid_i = hold_req;
    bus.req_rs_i    = 1'b1;
    bus.req_data_i  = 8'h55;
    rst = 1'b0;
    for (int t = 1; t <= 1000 && done_t < 0; t++) begin
      @(posedge clk);
      @(negedge clk);
      if (t == 1) check("pwrup_lcd_on", 32'(lcd_on), 32'd1);
      if (lcd_en && !pe) begin
        if (nr < 6) begin
          rise_t[nr] = t;
          rise_d[nr] = lcd_data;
        end
        nr++;
      end
      if (!lcd_en && pe && nr >= 1 && nr <= 6) fall_t[nr-1] = t;
      if (lcd_rs) rs_seen = 1'b1;
      if (bus.req_ready_o && !bus.init_done_o) early = 1'b1;
      if (bus.init_done_o) done_t = t;
      pe = lcd_en;
    end
    check("init_pulse_count", 32'(nr), 32'd6);
    check("init_first_rise", 32'(rise_t[0]), 32'(P_PWR + 1 + P_S));
    for (int i = 0; i < 6; i++) begin
      check($sformatf("init_data%0d", i), 32'(rise_d[i]), 32'(exp_seq[i]));
      check($sformatf("init_width%0d", i), 32'(fall_t[i] - rise_t[i]), 32'(P_EN));
      if (i > 0) begin
        gap = P_EN + P_H + 1 + P_S + ((i - 1 == 4) ? P_CLR : P_CMD);
        check($sformatf("init_gap%0d", i), 32'(rise_t[i] - rise_t[i-1]), 32'(gap));
      end
    end
    check("init_done_time", 32'(done_t), 32'(rise_t[5] + P_EN + P_H + P_CMD));
    check("init_ready_after", 32'(bus.req_ready_o), 32'd1);
    check("init_busy_after", 32'(bus.busy_o), 32'd0);
    check("init_rs_stayed_0", 32'(rs_seen), 32'd0);
    check("init_no_early_ready", 32'(early), 32'd0);
    if (hold_req) begin
      @(posedge clk);
      @(negedge clk);
      check("held_req_accepted", 32'(bus.req_ready_o), 32'd0);
      bus.req_valid_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("held_req_data", 32'(lcd_data), 32'h55);
      check("held_req_rs", 32'(lcd_rs), 32'd1);
      wait_ready("held_req");
    end
  endtask

  task automatic send_check(input logic rs_v, input logic [7:0] d, input int w, input string name);
    int  rise = -1;
    int  fall = -1;
    int  rdy = -1;
    bit  unstable = 1'b0;
    wait_ready(name);
    bus.req_valid_i = 1'b1;
    bus.req_rs_i    = rs_v;
    bus.req_data_i  = d;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    bus.req_data_i  = ~d;
    bus.req_rs_i    = ~rs_v;
    check({name, "_ready_fall"}, 32'(bus.req_ready_o), 32'd0);
    for (int t = 1; t <= 200 && rdy < 0; t++) begin
      @(posedge clk);
      @(negedge clk);
      if (lcd_en && rise < 0) rise = t;
      if (!lcd_en && rise >= 0 && fall < 0) fall = t;
      if (t <= 1 + P_S + P_EN + P_H && (lcd_data !== d || lcd_rs !== rs_v)) unstable = 1'b1;
      if (bus.req_ready_o) rdy = t;
    end
    check({name, "_en_rise"}, 32'(rise), 32'(1 + P_S));
    check({name, "_en_fall"}, 32'(fall), 32'(1 + P_S + P_EN));
    check({name, "_ready_back"}, 32'(rdy), 32'(1 + P_S + P_EN + P_H + w));
    check({name, "_bus_stable"}, 32'(unstable), 32'd0);
    check({name, "_rw"}, 32'(lcd_rw), 32'd0);
  endtask

  vec_t vecs [6];

  initial begin
    int         t;
    bit         got;
    logic [7:0] exp_b;
    bit         unstable;

    vecs[0] = '{rs: 1'b1, data: 8'h41, wait_cyc: P_CMD};
    vecs[1] = '{rs: 1'b0, data: 8'h01, wait_cyc: P_CLR};
    vecs[2] = '{rs: 1'b1, data: 8'h01, wait_cyc: P_CMD};
    vecs[3] = '{rs: 1'b0, data: 8'h02, wait_cyc: P_CLR};
    vecs[4] = '{rs: 1'b0, data: 8'h38, wait_cyc: P_CMD};
    vecs[5] = '{rs: 1'b1, data: 8'h02, wait_cyc: P_CMD};

    bus.req_valid_i = 1'b0;
    bus.req_rs_i    = 1'b0;
    bus.req_data_i  = 8'h00;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_outputs("reset");

    // Request held valid through power-up and init; must land on the first ready cycle.
    run_init(1'b1);

    for (int i = 0; i < 6; i++) begin
      send_check(vecs[i].rs, vecs[i].data, vecs[i].wait_cyc, $sformatf("vec%0d", i));
    end

    // Valid held with a changing byte during a transfer.
    wait_ready("chg");
    bus.req_valid_i = 1'b1;
    bus.req_rs_i    = 1'b1;
    bus.req_data_i  = 8'h20;
    @(posedge clk);
    t = 0;
    got = 1'b0;
    unstable = 1'b0;
    exp_b = 8'h00;
    while (!got && t < 100) begin
      @(negedge clk);
      if (t >= 1 && t <= 1 + P_S + P_EN + P_H && lcd_data !== 8'h20) unstable = 1'b1;
      if (bus.req_ready_o) begin
        exp_b = 8'(8'h60 + t);
        bus.req_data_i = exp_b;
        got = 1'b1;
      end else begin
        bus.req_data_i = 8'(8'h80 + t);
        @(posedge clk);
        t++;
      end
    end
    check("chg_stable", 32'(unstable), 32'd0);
    check("chg_ready_back", 32'(t), 32'(1 + P_S + P_EN + P_H + P_CMD));
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    check("chg_second_accept", 32'(bus.req_ready_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("chg_second_data", 32'(lcd_data), 32'(exp_b));

    // Reset while EN is high.
    wait_ready("rst_mid");
    bus.req_valid_i = 1'b1;
    bus.req_rs_i    = 1'b1;
    bus.req_data_i  = 8'h33;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    t = 0;
    while (!lcd_en && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("rst_mid_en_seen", 32'(lcd_en), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_mid");
    repeat (4) @(negedge clk);
    run_init(1'b0);
    repeat (3) @(negedge clk);
    check("post_init_ready_stays", 32'(bus.req_ready_o), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
